fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: the instruction-memory request/response channel,
// the branch redirect inputs and the instruction-buffer head seen by the
// consumer. The master modport is the fetch unit, the slave modport is the
// surrounding memory/pipeline environment.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_ready, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_ready, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetch requests, tracks
// in-flight requests, buffers in-order responses together with their PC,
// and flushes on redirect by counting down responses that became stale.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] START_PC   = RESET_PC & ALIGN_MASK;
  localparam logic [CW:0]     DEPTH_W    = (CW + 1)'(DEPTH);

  typedef enum logic {NORMAL, FLUSH} mode_t;

  mode_t           mode_reg, mode_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   drop_reg, drop_next;

  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [CW:0]     occupancy;
  logic            req;
  logic            accept;
  logic            rsp;
  logic            flushing;
  logic            push;
  logic            pop;
  logic            head_valid;
  logic [XLEN-1:0] target_pc;

  // Buffered plus in-flight entries must stay below DEPTH so every
  // accepted request is guaranteed a buffer slot when it returns.
  assign occupancy  = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign req        = rst && !bus.redirect && (occupancy < DEPTH_W);
  assign accept     = req && bus.mem_ready;
  // A response with nothing outstanding is spurious (e.g. left over from
  // before a reset) and is ignored so counters cannot underflow.
  assign rsp        = bus.mem_rvalid && (outstanding_reg != '0);
  assign flushing   = (mode_reg == FLUSH);
  assign push       = rsp && !bus.redirect && !flushing;
  assign head_valid = rst && (count_reg != '0);
  assign pop        = head_valid && bus.inst_ready && !bus.redirect;
  assign target_pc  = bus.redirect_pc & ALIGN_MASK;

  assign bus.mem_req    = req;
  assign bus.mem_addr   = rst ? pc_reg : START_PC;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head_valid ? inst_mem[rd_ptr_reg] : 32'h0;
  assign bus.inst_pc    = head_valid ? pc_mem[rd_ptr_reg] : '0;

  // Next-state logic: fetch PC, response PC, buffer pointers, counters and mode.
  always_comb begin
    pc_next          = pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    count_next       = count_reg;
    drop_next        = drop_reg;
    outstanding_next = outstanding_reg + CW'(accept) - CW'(rsp);

    if (accept) begin
      pc_next = pc_reg + XLEN'(4);
    end

    if (bus.redirect) begin
      // Redirect wins over push/pop: the buffer empties and every request
      // still in flight (minus one answered this cycle) becomes stale.
      pc_next     = target_pc;
      rsp_pc_next = target_pc;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      drop_next   = outstanding_reg - CW'(rsp);
    end else begin
      if (flushing && rsp) begin
        drop_next = drop_reg - CW'(1);
      end
      // Responses return in order, so the PC of the next kept response
      // simply advances by one word per kept response.
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
        rsp_pc_next = rsp_pc_reg + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      count_next = count_reg + CW'(push) - CW'(pop);
    end

    mode_next = (drop_next != '0) ? FLUSH : NORMAL;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_reg        <= NORMAL;
      pc_reg          <= START_PC;
      rsp_pc_reg      <= START_PC;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_reg        <= '0;
    end else begin
      mode_reg        <= mode_next;
      pc_reg          <= pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
    end
  end

  // Buffer storage write: instruction word and the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      inst_mem[wr_ptr_reg] <= bus.mem_rdata;
      pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming fetch, back-pressure, stalls,
// redirects with stale responses, mid-operation reset and PC wrap-around.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) b();
  fetch_unit_if #(.XLEN(32)) b2();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'h1300_0000 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] b2_exp [3];
    logic        prev_acc;
    logic [31:0] prev_addr;
    logic        cur_acc;
    logic [31:0] cur_addr;
    int          accepted;

    b2_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    rst = 1'b0;
    b.mem_ready = 1'b0; b.mem_rvalid = 1'b0; b.mem_rdata = '0;
    b.redirect = 1'b0; b.redirect_pc = '0; b.inst_ready = 1'b0;
    b2.mem_ready = 1'b1; b2.mem_rvalid = 1'b0; b2.mem_rdata = '0;
    b2.redirect = 1'b0; b2.redirect_pc = '0; b2.inst_ready = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_mem_req", b.mem_req, 1'b0);
    check("rst_mem_addr", b.mem_addr, 32'h0);
    check("rst_inst_valid", b.inst_valid, 1'b0);
    check("rst_inst", b.inst, 32'h0);
    check("rst_inst_pc", b.inst_pc, 32'h0);
    check("rst2_mem_addr", b2.mem_addr, 32'hFFFF_FFF8);
    check("rst2_mem_req", b2.mem_req, 1'b0);

    // Streaming fetch, 1-cycle latency, consumer always ready
    rst = 1'b1; b.mem_ready = 1'b1; b.inst_ready = 1'b1;
    #1;
    check("first_req", b.mem_req, 1'b1);
    for (int k = 0; k < 5; k++) begin
      b.mem_rvalid = (k > 0);
      b.mem_rdata  = dat(32'(4 * (k - 1)));
      #1;
      check("stream_addr", b.mem_addr, 32'(4 * k));
      if (k < 3) check("wrap_addr", b2.mem_addr, b2_exp[k]);
      tick();
      if (k > 0) begin
        check("stream_valid", b.inst_valid, 1'b1);
        check("stream_pc", b.inst_pc, 32'(4 * (k - 1)));
        check("stream_inst", b.inst, dat(32'(4 * (k - 1))));
      end
    end
    b.mem_ready = 1'b0; b.mem_rvalid = 1'b1; b.mem_rdata = dat(32'd16);
    tick();
    check("tail_pc", b.inst_pc, 32'd16);
    check("tail_inst", b.inst, dat(32'd16));
    b.mem_rvalid = 1'b0;
    tick();
    check("drained_valid", b.inst_valid, 1'b0);

    // Memory stall: request and address held
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_req", b.mem_req, 1'b1);
      check("stall_addr", b.mem_addr, 32'd20);
      tick();
      check("stall_valid", b.inst_valid, 1'b0);
    end

    // Reset in the middle of a burst
    b.mem_ready = 1'b1;
    tick();
    b.mem_rvalid = 1'b1; b.mem_rdata = dat(32'd20);
    tick();
    check("burst_valid", b.inst_valid, 1'b1);
    check("burst_pc", b.inst_pc, 32'd20);
    rst = 1'b0; b.mem_rvalid = 1'b0;
    tick();
    check("midrst_req", b.mem_req, 1'b0);
    check("midrst_addr", b.mem_addr, 32'h0);
    check("midrst_valid", b.inst_valid, 1'b0);
    check("midrst_inst", b.inst, 32'h0);
    check("midrst_pc", b.inst_pc, 32'h0);
    rst = 1'b1; b.mem_ready = 1'b0; b.mem_rvalid = 1'b1; b.mem_rdata = 32'hBAD0_0001;
    #1;
    check("postrst_req", b.mem_req, 1'b1);
    tick();
    check("postrst_ignored", b.inst_valid, 1'b0);
    b.mem_rvalid = 1'b0;

    // Consumer stalled: buffer fills, then requests stop
    b.inst_ready = 1'b0; b.mem_ready = 1'b1;
    prev_acc = 1'b0; prev_addr = '0; accepted = 0;
    for (int i = 0; i < 8; i++) begin
      b.mem_rvalid = prev_acc;
      b.mem_rdata  = dat(prev_addr);
      #1;
      cur_acc  = b.mem_req && b.mem_ready;
      cur_addr = b.mem_addr;
      tick();
      accepted += int'(cur_acc);
      prev_acc  = cur_acc;
      prev_addr = cur_addr;
    end
    b.mem_rvalid = 1'b0;
    #1;
    check("full_accepted", 32'(accepted), 32'd4);
    check("full_req", b.mem_req, 1'b0);
    check("full_valid", b.inst_valid, 1'b1);
    check("full_pc", b.inst_pc, 32'h0);
    check("full_inst", b.inst, dat(32'h0));
    b.mem_ready = 1'b0; b.inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_pc", b.inst_pc, 32'(4 * i));
      tick();
    end
    check("drain_empty", b.inst_valid, 1'b0);

    // Redirect with three outstanding requests
    b.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("pre_redir_addr", b.mem_addr, 32'(16 + 4 * i));
      tick();
    end
    b.redirect = 1'b1; b.redirect_pc = 32'h0000_0103;
    #1;
    check("redir_req", b.mem_req, 1'b0);
    tick();
    b.redirect = 1'b0;
    #1;
    check("redir_addr", b.mem_addr, 32'h0000_0100);
    check("redir_req_after", b.mem_req, 1'b1);
    tick();
    #1;
    check("stale_limit", b.mem_req, 1'b0);
    b.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b.mem_rvalid = 1'b1; b.mem_rdata = 32'hDEAD_0000 + 32'(i);
      tick();
      check("stale_dropped", b.inst_valid, 1'b0);
    end
    b.mem_rdata = dat(32'h100);
    tick();
    b.mem_rvalid = 1'b0;
    check("flush_valid", b.inst_valid, 1'b1);
    check("flush_pc", b.inst_pc, 32'h0000_0100);
    check("flush_inst", b.inst, dat(32'h100));
    tick();
    check("flush_popped", b.inst_valid, 1'b0);

    // Redirect coinciding with a response, two outstanding
    b.mem_ready = 1'b1;
    #1;
    check("r2_addr", b.mem_addr, 32'h0000_0104);
    tick(); tick();
    b.mem_ready = 1'b0;
    b.redirect = 1'b1; b.redirect_pc = 32'h0000_0200;
    b.mem_rvalid = 1'b1; b.mem_rdata = 32'hDEAD_1000;
    tick();
    b.redirect = 1'b0; b.mem_rdata = 32'hDEAD_1001;
    tick();
    check("r2_one_dropped", b.inst_valid, 1'b0);
    b.mem_rvalid = 1'b0; b.mem_ready = 1'b1;
    #1;
    check("r2_new_addr", b.mem_addr, 32'h0000_0200);
    check("r2_new_req", b.mem_req, 1'b1);
    tick();
    b.mem_ready = 1'b0; b.mem_rvalid = 1'b1; b.mem_rdata = dat(32'h200);
    tick();
    b.mem_rvalid = 1'b0;
    check("r2_kept_valid", b.inst_valid, 1'b1);
    check("r2_kept_pc", b.inst_pc, 32'h0000_0200);
    check("r2_kept_inst", b.inst, dat(32'h200));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
